// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared types and sizing for the multiplier arbiter
package mult_arb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef logic port_t;

  localparam int SIZE_DEFAULT    = 8;
  localparam int TIMEOUT_DEFAULT = 4 * SIZE_DEFAULT + 8;

  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int WD_WIDTH = $clog2(TIMEOUT_DEFAULT + 1);

endpackage

// File: rtl/mult_arb_if.sv
// rtl/mult_arb_if.sv - client and multiplier signals of the multiplier arbiter
interface mult_arb_if #(parameter int SIZE = 8);

  logic                req0;
  logic                req1;
  logic [SIZE-1:0]     a0;
  logic [SIZE-1:0]     b0;
  logic [SIZE-1:0]     a1;
  logic [SIZE-1:0]     b1;
  logic                done0;
  logic                done1;
  logic [2*SIZE-1:0]   prod0;
  logic [2*SIZE-1:0]   prod1;
  logic                mult_start;
  logic [SIZE-1:0]     mult_a;
  logic [SIZE-1:0]     mult_b;
  logic                mult_end;
  logic [2*SIZE-1:0]   mult_product;
  logic                busy;
  logic                timeout_err;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mult_end, mult_product,
    output done0, done1, prod0, prod1, mult_start, mult_a, mult_b, busy, timeout_err
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, mult_end, mult_product,
    input  done0, done1, prod0, prod1, mult_start, mult_a, mult_b, busy, timeout_err
  );

endinterface

// File: rtl/mult_arb_watchdog.sv
// rtl/mult_arb_watchdog.sv - saturating cycle counter with terminal flag
module mult_arb_watchdog #(
  parameter int LIMIT = 40,
  parameter int WIDTH = $clog2(LIMIT + 1)
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic i_clr,
  input  logic i_en,
  output logic o_terminal
);

  logic [WIDTH-1:0] r_count;
  logic             w_terminal;

  assign w_terminal = (r_count == WIDTH'(LIMIT));
  assign o_terminal = w_terminal;

  // Holds at LIMIT so a stuck multiplier never wraps the count back to zero.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      r_count <= '0;
    else if (i_clr)
      r_count <= '0;
    else if (i_en && !w_terminal)
      r_count <= r_count + 1'b1;
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sharing of one multiplier between two ports
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int TIMEOUT = 4 * SIZE + 8
) (
  input  logic     CLOCK,
  input  logic     RESET,
  mult_arb_if.slave bus
);

  state_t              r_state;
  state_t              w_next;
  port_t               r_grant;
  port_t               r_last_grant;
  port_t               w_pick;
  logic [SIZE-1:0]     r_mult_a;
  logic [SIZE-1:0]     r_mult_b;
  logic [2*SIZE-1:0]   r_prod0;
  logic [2*SIZE-1:0]   r_prod1;
  logic                r_done0;
  logic                r_done1;
  logic                r_timeout_err;
  logic                w_terminal;
  logic                w_req_any;
  logic                w_grant;
  logic                w_mult_start;
  logic                w_busy;

  assign w_req_any = bus.req0 | bus.req1;
  assign w_grant   = (r_state == IDLE) && w_req_any;

  always_comb begin
    w_pick = 1'b0;
    if (bus.req0 && bus.req1)
      w_pick = ~r_last_grant;
    else if (bus.req1)
      w_pick = 1'b1;
  end

  mult_arb_watchdog #(
    .LIMIT (TIMEOUT),
    .WIDTH (wd_width(TIMEOUT))
  ) u_watchdog (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .i_clr      (r_state != RUN),
    .i_en       (r_state == RUN),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // DRAIN waits for END_MULT to fall so the multiplier is idle before a re-grant.
  always_comb begin
    w_next       = r_state;
    w_mult_start = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_req_any)
          w_next = RUN;
      end
      RUN: begin
        w_mult_start = 1'b1;
        if (bus.mult_end || w_terminal)
          w_next = DRAIN;
      end
      DRAIN: begin
        if (!bus.mult_end)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_grant       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_mult_a      <= '0;
      r_mult_b      <= '0;
      r_prod0       <= '0;
      r_prod1       <= '0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_grant) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        r_mult_a     <= w_pick ? bus.a1 : bus.a0;
        r_mult_b     <= w_pick ? bus.b1 : bus.b0;
      end
      // A real result beats the watchdog when both land on the same edge.
      if (r_state == RUN && bus.mult_end) begin
        if (r_grant) begin
          r_prod1 <= bus.mult_product;
          r_done1 <= 1'b1;
        end else begin
          r_prod0 <= bus.mult_product;
          r_done0 <= 1'b1;
        end
      end else if (r_state == RUN && w_terminal) begin
        r_timeout_err <= 1'b1;
        if (r_grant) begin
          r_prod1 <= '0;
          r_done1 <= 1'b1;
        end else begin
          r_prod0 <= '0;
          r_done0 <= 1'b1;
        end
      end
    end
  end

  assign bus.mult_start  = w_mult_start;
  assign bus.busy        = w_busy;
  assign bus.mult_a      = r_mult_a;
  assign bus.mult_b      = r_mult_b;
  assign bus.prod0       = r_prod0;
  assign bus.prod1       = r_prod1;
  assign bus.done0       = r_done0;
  assign bus.done1       = r_done1;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Two-port arbiter and sequencer that shares one sum-and-shift multiplier between two requesters. It accepts operand pairs over a req/done handshake and grants the multiplier round-robin. It drives the multiplier's START level, waits for END_MULT and returns the product to the granted requester. A watchdog flags a multiplier that never finishes. It sits between client logic and the multiplier instance, which shares CLOCK and RESET.

## Interface
- SIZE, 8, operand width; product is 2*SIZE bits
- TIMEOUT, 4*SIZE+8, maximum cycles in RUN before the watchdog fires
- CLOCK  in  1  clock, rising edge
- RESET  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  request from port 0 / 1; held high with stable operands until that port's done
- a0, b0 / a1, b1  in  SIZE  operands, port 0 / 1
- done0 / done1  out  1  one-cycle pulse: product valid on port 0 / 1
- prod0 / prod1  out  2*SIZE  product register, port 0 / 1; holds until the next completion on that port
- mult_start  out  1  START level to the multiplier
- mult_a, mult_b  out  SIZE  latched operands to the multiplier
- mult_end  in  1  END_MULT from the multiplier
- mult_product  in  2*SIZE  multiplier result
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE, at least one req high:
  - Select a port; latch its operands into mult_a/mult_b and its id into grant.
  - Go to RUN.
- Arbitration, round-robin, evaluated in IDLE only:
  - A single request wins outright.
  - If both are high, the port not recorded in last_grant wins.
  - last_grant updates on every grant; reset value is 1, so port 0 wins the first tie.
- RUN:
  - mult_start=1; watchdog counts from 0.
  - mult_end sampled high: prod[grant] <= mult_product, done[grant] set for the next cycle, go to DRAIN.
  - Count reaches TIMEOUT with mult_end low: timeout_err <= 1, prod[grant] <= 0, done[grant] set, go to DRAIN.
- DRAIN:
  - mult_start=0; the done pulse is visible in the first DRAIN cycle.
  - Stay until mult_end sampled low, then go to IDLE.
- Operand registers and mult_a/mult_b change only on a grant.
- A req still high after its done counts as a new request, still subject to round-robin.
- A req dropped before grant is ignored. Dropping req after grant is a protocol violation; the operation still completes and done still pulses.
- timeout_err clears only on RESET.

## Timing
- Reset values: all outputs 0; state IDLE; last_grant=1; watchdog=0.
- RESET mid-operation aborts immediately; no done is issued.
- Latencies:
  - req sampled high in IDLE (edge k) -> mult_start high from cycle k+1.
  - mult_end sampled high at edge m -> done and prod valid in cycle m+1, mult_start low in cycle m+1.
  - Minimum request-to-done latency is multiplier latency + 2 cycles.
- Back-to-back: at least one IDLE cycle between operations, so turnaround is DRAIN plus one IDLE cycle.
- Multiplier coupling: it returns to its idle state only after START falls, so DRAIN must see mult_end low before a re-grant. This guarantees it never sees a START held over from the previous operation.
- Watchdog width: $clog2(TIMEOUT+1) bits; saturates and never wraps.
- If mult_end and the timeout coincide on the same edge, mult_end wins and timeout_err stays 0.

## Structure
- Package mult_arb_pkg holds:
  - state enum typedef {IDLE, RUN, DRAIN}
  - port id typedef (1 bit)
  - localparam computing the watchdog width from TIMEOUT
- Sub-module mult_arb_watchdog: counter with clear, enable and saturate, plus a terminal flag; instantiated once.
- The arbitration and FSM stay in mult_arbiter.

## Test plan
- Single request: port 0 with a0=8'd7, b0=8'd6. Required response: exactly one done0 with prod0=16'd42, no done1, busy low again after DRAIN.
- Simultaneous requests: req0 and req1 rise on the same edge after reset. Required response: port 0 served first, then port 1; each done pulses once with the correct products, e.g. 3*5=15, then 255*255=65025.
- Fairness: req0 and req1 held high continuously for 6 operations. Required response: grants alternate 0,1,0,1,0,1; mult_start is low for at least one cycle between operations.
- Timeout: multiplier model never asserts mult_end. Required response: at cycle TIMEOUT in RUN, timeout_err=1, done0 pulses with prod0=0, and the FSM returns to IDLE.
- Reset mid-RUN: assert RESET while mult_start is high. Required response: all outputs 0 immediately, no done; the next request completes normally.
- Coincident edge: mult_end rises on the same edge the watchdog reaches TIMEOUT. Required response: timeout_err stays 0 and prod holds the product.
